// File: rtl/sa_pkg.sv
// Shared constants and state encoding for the systolic-array AXI read path.
package sa_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam int         AXI_PAGE_BYTES = 4096;

    typedef enum logic [2:0] {
        RD_IDLE,
        RD_AR_WAIT,
        RD_AR,
        RD_R,
        RD_DRAIN,
        RD_DONE
    } rd_state_e;

endpackage

// File: rtl/sa_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; head word visible the cycle after its push.
// Latency 1 cycle push-to-head; push when full and pop when empty are dropped.
// Backpressure: producer must respect full/count, consumer pops only when !empty.
module sa_sync_fifo #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

    // Storage is not reset; flushing only needs the pointers cleared.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/sa_axi_rd_dma.sv
// AXI4 read burst engine: splits a word request into 4 KB-safe bursts, streams words out via FIFO.
// Latency: start -> ARVALID after 2 cycles; R beat -> o_dout_valid next cycle.
// Backpressure: a burst is issued only when the FIFO has room for it, so RREADY never drops mid-burst.
// Optional SA_AXI_RD_DMA_RESP_CHECK_EN: sticky o_err on RRESP != OKAY or RID != 0.
module sa_axi_rd_dma
    import sa_pkg::*;
#(
    parameter int AXI_WIDTH_AD = 32,
    parameter int AXI_WIDTH_ID = 4,
    parameter int AXI_WIDTH_DA = 32,
    parameter int MAX_BURST    = 16,
    parameter int FIFO_DEPTH   = 32
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    i_start,
    input  logic [AXI_WIDTH_AD-1:0] i_base_addr,
    input  logic [15:0]             i_num_words,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_err,
    output logic                    M_ARVALID,
    input  logic                    M_ARREADY,
    output logic [AXI_WIDTH_AD-1:0] M_ARADDR,
    output logic [AXI_WIDTH_ID-1:0] M_ARID,
    output logic [7:0]              M_ARLEN,
    output logic [2:0]              M_ARSIZE,
    output logic [1:0]              M_ARBURST,
    input  logic                    M_RVALID,
    output logic                    M_RREADY,
    input  logic [AXI_WIDTH_DA-1:0] M_RDATA,
    input  logic                    M_RLAST,
    input  logic [AXI_WIDTH_ID-1:0] M_RID,
    input  logic [1:0]              M_RRESP,
    output logic                    o_dout_valid,
    input  logic                    i_dout_ready,
    output logic [AXI_WIDTH_DA-1:0] o_dout_data
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    rd_state_e             state;
    logic [AXI_WIDTH_AD-1:0] base_addr;
    logic [AXI_WIDTH_AD-1:0] cur_addr;
    logic [15:0]           total_words;
    logic [15:0]           words_done;
    logic [15:0]           rem_words;
    logic [15:0]           page_words;
    logic [15:0]           free_slots;
    logic [15:0]           burst_len;
    logic [CW-1:0]         fifo_cnt;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  beat;
    logic                  start_acc;
    logic                  more_words;
    logic                  unused_sigs;

    assign start_acc  = i_start && (state == RD_IDLE);
    assign beat       = M_RVALID && M_RREADY;
    assign cur_addr   = base_addr + AXI_WIDTH_AD'({words_done, 2'b00});
    assign rem_words  = total_words - words_done;
    assign page_words = 16'(AXI_PAGE_BYTES / 4) - 16'(cur_addr[11:2]);
    assign free_slots = 16'(FIFO_DEPTH) - 16'(fifo_cnt);
    // Progress is counted in beats actually received, so a short or long RLAST self-corrects.
    assign more_words = (words_done + 16'd1) < total_words;

    assign M_ARID    = '0;
    assign M_ARSIZE  = 3'($clog2(AXI_WIDTH_DA / 8));
    assign M_ARBURST = AXI_BURST_INCR;

    always_comb begin
        burst_len = rem_words;
        if (burst_len > 16'(MAX_BURST)) burst_len = 16'(MAX_BURST);
        if (burst_len > page_words)     burst_len = page_words;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= RD_IDLE;
            base_addr   <= '0;
            total_words <= '0;
            words_done  <= '0;
            M_ARVALID   <= 1'b0;
            M_ARADDR    <= '0;
            M_ARLEN     <= '0;
            M_RREADY    <= 1'b0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                RD_IDLE: begin
                    if (start_acc) begin
                        base_addr   <= {i_base_addr[AXI_WIDTH_AD-1:2], 2'b00};
                        total_words <= i_num_words;
                        words_done  <= '0;
                        o_busy      <= 1'b1;
                        if (i_num_words == 16'd0) begin
                            state  <= RD_DONE;
                            o_done <= 1'b1;
                        end else begin
                            state <= RD_AR_WAIT;
                        end
                    end
                end
                RD_AR_WAIT: begin
                    if (free_slots >= burst_len) begin
                        M_ARVALID <= 1'b1;
                        M_ARADDR  <= cur_addr;
                        M_ARLEN   <= 8'(burst_len - 16'd1);
                        state     <= RD_AR;
                    end
                end
                RD_AR: begin
                    if (M_ARREADY) begin
                        M_ARVALID <= 1'b0;
                        M_RREADY  <= 1'b1;
                        state     <= RD_R;
                    end
                end
                RD_R: begin
                    if (beat) begin
                        words_done <= words_done + 16'd1;
                        if (M_RLAST) begin
                            M_RREADY <= 1'b0;
                            state    <= more_words ? RD_AR_WAIT : RD_DRAIN;
                        end
                    end
                end
                RD_DRAIN: begin
                    if (fifo_empty) begin
                        state  <= RD_DONE;
                        o_done <= 1'b1;
                    end
                end
                RD_DONE: begin
                    state  <= RD_IDLE;
                    o_busy <= 1'b0;
                end
                default: state <= RD_IDLE;
            endcase
        end
    end

    sa_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (AXI_WIDTH_DA)
    ) u_fifo (
        .clk      (clk),
        .rstn     (rstn),
        .push     (beat),
        .push_dat (M_RDATA),
        .pop      (o_dout_valid && i_dout_ready),
        .pop_dat  (o_dout_data),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_cnt)
    );

    assign o_dout_valid = !fifo_empty;

`ifdef SA_AXI_RD_DMA_RESP_CHECK_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            o_err <= 1'b0;
        else if (start_acc)
            o_err <= 1'b0;
        else if (beat && ((M_RRESP != AXI_RESP_OKAY) || (M_RID != '0)))
            o_err <= 1'b1;
    end
    assign unused_sigs = ^{fifo_full, i_base_addr[1:0]};
`else
    assign o_err       = 1'b0;
    assign unused_sigs = ^{fifo_full, i_base_addr[1:0], M_RRESP, M_RID};
`endif

endmodule
